// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: bf16 field layout, encodings and the
// state enum used by the sequential bf16 adder.
package fpu_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] man;
  } bf16_t;

  localparam int          BF16_BIAS    = 127;
  localparam logic [7:0]  BF16_EXP_MAX = 8'hFF;
  localparam logic [15:0] BF16_QNAN    = 16'h7FC0;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    DONE
  } add_state_e;

endpackage

// File: rtl/bf16_lzc.sv
// 12-bit leading-zero counter for the adder's normalisation step.
// An all-zero input reports 12.
module bf16_lzc (
  input  logic [11:0] x,
  output logic [3:0]  cnt
);

  // Scanning upward lets the most significant set bit win.
  always_comb begin
    cnt = 4'd12;
    for (int i = 0; i < 12; i++) begin
      if (x[i]) cnt = 4'(11 - i);
    end
  end

endmodule

// File: rtl/bf16_add_seq.sv
// Multi-cycle bfloat16 add/subtract (IDLE->ALIGN->ADD->NORM->DONE), RNE, FTZ.
// Define BF16_ADD_FLAGS_EN to add flags_o = {invalid, overflow, underflow, inexact}.
module bf16_add_seq
  import fpu_pkg::*;
#(
  parameter logic [15:0] QNAN    = BF16_QNAN,
  parameter int          GUARD_W = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sub_i,
  output logic        valid_o,
  input  logic        ready_i,
`ifdef BF16_ADD_FLAGS_EN
  output logic [3:0]  flags_o,
`endif
  output logic [15:0] result_o
);

  localparam int SIG_W   = 8 + GUARD_W;
  localparam int SUM_W   = SIG_W + 1;
  localparam int EXP_INF = 2 * BF16_BIAS + 1;

  add_state_e state, state_nx;

  logic [15:0]             a_r, b_r;
  logic                    sx_r, sub_r, spec_r;
  logic signed [9:0]       ex_r;
  logic [SIG_W-1:0]        sig_x_r, sig_y_r;
  logic [15:0]             spec_res_r;
  logic [SUM_W-1:0]        sum_r;

  function automatic logic [SIG_W-1:0] align_sticky(input logic [SIG_W-1:0] sig,
                                                    input logic [7:0] d);
    logic [SIG_W-1:0] mask;
    if (d > 8'(SIG_W - 1)) return {{(SIG_W-1){1'b0}}, |sig};
    mask = ~({SIG_W{1'b1}} << d);
    return (sig >> d) | {{(SIG_W-1){1'b0}}, |(sig & mask)};
  endfunction

  // Returns the rounded 8-bit significand with its carry in bit 8.
  function automatic logic [8:0] round_rne(input logic [SUM_W-1:0] n);
    logic g, r, s, up;
    g  = n[GUARD_W];
    r  = n[GUARD_W-1];
    s  = |n[GUARD_W-2:0];
    up = g & (r | s | n[GUARD_W+1]);
    return {1'b0, n[SUM_W-1 -: 8]} + {8'b0, up};
  endfunction

  function automatic logic [15:0] pack_sat(input logic s, input logic signed [9:0] e,
                                           input logic [6:0] m);
    if (e >= 10'(EXP_INF)) return {s, BF16_EXP_MAX, 7'h00};
    if (e <= 10'sd0)       return {s, 15'h0000};
    return {s, e[7:0], m};
  endfunction

  // ---- control FSM ----
  always_comb begin
    state_nx = state;
    ready_o  = 1'b0;
    case (state)
      IDLE: begin
        ready_o = 1'b1;
        if (valid_i) state_nx = ALIGN;
      end
      ALIGN:   state_nx = ADD;
      ADD:     state_nx = NORM;
      NORM:    state_nx = DONE;
      DONE:    if (ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ---- ALIGN: unpack, classify, order by magnitude, align Y ----
  bf16_t            a_u, b_u, x, y;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [SIG_W-1:0] sig_x, sig_y;
  logic             spec_hit, spec_inv;
  logic [15:0]      spec_res;

  always_comb begin
    a_u    = a_r;
    b_u    = b_r;
    a_zero = (a_u.exp == 8'h00);
    b_zero = (b_u.exp == 8'h00);
    a_inf  = (a_u.exp == BF16_EXP_MAX) && (a_u.man == 7'h00);
    b_inf  = (b_u.exp == BF16_EXP_MAX) && (b_u.man == 7'h00);
    a_nan  = (a_u.exp == BF16_EXP_MAX) && (a_u.man != 7'h00);
    b_nan  = (b_u.exp == BF16_EXP_MAX) && (b_u.man != 7'h00);
    swap   = (b_zero ? 15'h0 : b_r[14:0]) > (a_zero ? 15'h0 : a_r[14:0]);
    x      = swap ? b_u : a_u;
    y      = swap ? a_u : b_u;
    sig_x  = (x.exp == 8'h00) ? '0 : {1'b1, x.man, {GUARD_W{1'b0}}};
    sig_y  = align_sticky((y.exp == 8'h00) ? '0 : {1'b1, y.man, {GUARD_W{1'b0}}},
                          x.exp - y.exp);

    spec_hit = 1'b1;
    spec_inv = 1'b0;
    spec_res = 16'h0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_u.sign != b_u.sign))) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf) begin
      spec_res = {a_u.sign, BF16_EXP_MAX, 7'h00};
    end else if (b_inf) begin
      spec_res = {b_u.sign, BF16_EXP_MAX, 7'h00};
    end else if (a_zero && b_zero) begin
      spec_res = {a_u.sign & b_u.sign, 15'h0000};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---- NORM: normalise, round, saturate ----
  logic [3:0]        lzc;
  logic [SUM_W-1:0]  norm;
  logic [8:0]        m9;
  logic [6:0]        man_r;
  logic signed [9:0] e_n, e_r;
  logic [15:0]       norm_res;

  bf16_lzc u_lzc (
    .x   (sum_r),
    .cnt (lzc)
  );

  always_comb begin
    norm     = sum_r << lzc;
    m9       = round_rne(norm);
    man_r    = m9[8] ? m9[7:1] : m9[6:0];
    e_n      = ex_r + 10'sd1 - $signed({6'b0, lzc});
    e_r      = e_n + $signed({9'b0, m9[8]});
    norm_res = (sum_r == '0) ? 16'h0000 : pack_sat(sx_r, e_r, man_r);
  end

  // Datapath registers carry no reset; their contents are only used once
  // the FSM has walked through the stage that loads them.
  always_ff @(posedge clk_i) begin
    case (state)
      IDLE: begin
        if (valid_i) begin
          a_r <= a_i;
          b_r <= b_i ^ {sub_i, 15'b0};
        end
      end
      ALIGN: begin
        sx_r       <= x.sign;
        sub_r      <= x.sign ^ y.sign;
        ex_r       <= $signed({2'b00, x.exp});
        sig_x_r    <= sig_x;
        sig_y_r    <= sig_y;
        spec_r     <= spec_hit;
        spec_res_r <= spec_res;
      end
      ADD: begin
        sum_r <= sub_r ? ({1'b0, sig_x_r} - {1'b0, sig_y_r})
                       : ({1'b0, sig_x_r} + {1'b0, sig_y_r});
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      valid_o  <= 1'b0;
      result_o <= 16'h0000;
    end else begin
      state <= state_nx;
      if (state == NORM) begin
        valid_o  <= 1'b1;
        result_o <= spec_r ? spec_res_r : norm_res;
      end else if ((state == DONE) && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

`ifdef BF16_ADD_FLAGS_EN
  logic inv_r, ovf, unf, inx;

  assign ovf = !spec_r && (sum_r != '0) && (e_r >= 10'(EXP_INF));
  assign unf = !spec_r && (sum_r != '0) && (e_r <= 10'sd0);
  assign inx = !spec_r && ((|norm[GUARD_W:0]) || ovf || unf);

  always_ff @(posedge clk_i) begin
    if (state == ALIGN) inv_r <= spec_inv;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)              flags_o <= 4'h0;
    else if (state == NORM) flags_o <= {spec_r & inv_r, ovf, unf, inx};
  end
`else
  logic unused_inv;
  assign unused_inv = spec_inv;
`endif

endmodule

// File: tb/tb_bf16_add_seq.sv
// Randomised bench for bf16_add_seq: a real-arithmetic reference model feeds an
// expected-result queue that a per-cycle compare process checks against the DUT.
module tb_bf16_add_seq;

  logic        clk = 1'b0;
  logic        rst_i, valid_i, ready_o, sub_i, valid_o, ready_i;
  logic [15:0] a_i, b_i, result_o;
`ifdef BF16_ADD_FLAGS_EN
  logic [3:0]  flags;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  bf16_add_seq dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .a_i      (a_i),
    .b_i      (b_i),
    .sub_i    (sub_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
`ifdef BF16_ADD_FLAGS_EN
    .flags_o  (flags),
`endif
    .result_o (result_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) repeat (n) r = r * 2.0;
    else        repeat (-n) r = r / 2.0;
    return r;
  endfunction

  function automatic real bf_val(input logic [15:0] v);
    real m;
    if (v[14:7] == 8'h00) return 0.0;
    m = real'({1'b1, v[6:0]}) * pow2(int'(v[14:7]) - 134);
    return v[15] ? -m : m;
  endfunction

  // Exact sum via doubles, then RNE to 8 significant bits with FTZ/overflow.
  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b0,
                                          input logic s);
    logic [15:0] b;
    logic        a_nan, b_nan, a_inf, b_inf, sg;
    real         r, mag, sc, frac;
    longint      t;
    int          e, be;
    b     = b0 ^ {s, 15'b0};
    a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 0);
    b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 0);
    a_inf = (a[14:7] == 8'hFF) && (a[6:0] == 0);
    b_inf = (b[14:7] == 8'hFF) && (b[6:0] == 0);
    if (a_nan || b_nan || (a_inf && b_inf && a[15] != b[15])) return 16'h7FC0;
    if (a_inf) return a;
    if (b_inf) return b;
    if (a[14:7] == 0 && b[14:7] == 0) return {a[15] & b[15], 15'h0};
    r = bf_val(a) + bf_val(b);
    if (r == 0.0) return 16'h0000;
    sg  = (r < 0.0);
    mag = sg ? -r : r;
    e   = 0;
    while (mag >= 2.0) begin mag = mag / 2.0; e++; end
    while (mag < 1.0)  begin mag = mag * 2.0; e--; end
    sc   = mag * 128.0;
    t    = longint'($floor(sc));
    frac = sc - real'(t);
    if (frac > 0.5 || (frac == 0.5 && t[0])) t++;
    if (t == 256) begin t = 128; e++; end
    be = e + 127;
    if (be >= 255) return {sg, 8'hFF, 7'h00};
    if (be <= 0)   return {sg, 15'h0000};
    return {sg, 8'(be), t[6:0]};
  endfunction

  always @(negedge clk) begin
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", {16'h0, result_o}, 32'hFFFF_FFFF);
      end else begin
        check("result", {16'h0, result_o}, {16'h0, exp_q[0]});
        if (ready_i) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic s,
                        input int hold, input logic early);
    int lat;
    @(posedge clk); #2;
    a_i = a; b_i = b; sub_i = s; valid_i = 1'b1; ready_i = early;
    @(negedge clk);
    check("ready_idle", {31'h0, ready_o}, 32'd1);
    @(posedge clk);
    exp_q.push_back(ref_add(a, b, s));
    #2 valid_i = 1'b0; a_i = 16'($urandom); b_i = 16'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!valid_o) check("ready_busy", {31'h0, ready_o}, 32'd0);
    end while (!valid_o && lat < 20);
    check("latency", lat, 32'd4);
    check("ready_done", {31'h0, ready_o}, 32'd0);
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #2;
        valid_i = 1'b1; a_i = 16'($urandom); b_i = 16'($urandom);
      end
      @(posedge clk); #2;
      ready_i = 1'b1; valid_i = 1'b0;
    end
    @(posedge clk);
    #2 ready_i = 1'b0;
    @(negedge clk);
    check("valid_cleared", {31'h0, valid_o}, 32'd0);
    check("ready_back", {31'h0, ready_o}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ra, rb;
    int          eb, k;
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; sub_i = 1'b0;
    a_i = 16'h0; b_i = 16'h0;

    check("pin_carry",  32'(ref_add(16'h3F80, 16'h3F80, 1'b0)), 32'h4000);
    check("pin_cancel", 32'(ref_add(16'h3F80, 16'h3F80, 1'b1)), 32'h0000);
    check("pin_tie_ev", 32'(ref_add(16'h3F80, 16'h3B80, 1'b0)), 32'h3F80);
    check("pin_tie_od", 32'(ref_add(16'h3F81, 16'h3B80, 1'b0)), 32'h3F82);
    check("pin_infinf", 32'(ref_add(16'h7F80, 16'hFF80, 1'b0)), 32'h7FC0);
    check("pin_ovf",    32'(ref_add(16'h7F7F, 16'h7F7F, 1'b0)), 32'h7F80);
    check("pin_negz",   32'(ref_add(16'h8000, 16'h0000, 1'b1)), 32'h8000);
    check("pin_two",    32'(ref_add(16'h4000, 16'h4000, 1'b0)), 32'h4080);

    repeat (3) @(negedge clk);
    check("rst_valid",  {31'h0, valid_o}, 32'd0);
    check("rst_result", {16'h0, result_o}, 32'h0);
    check("rst_ready",  {31'h0, ready_o}, 32'd1);
    rst_i = 1'b0;

    run_op(16'h3F80, 16'h3F80, 1'b0, 0, 1'b0);
    run_op(16'h3F80, 16'h3F80, 1'b1, 0, 1'b1);
    run_op(16'h3F80, 16'h3B80, 1'b0, 1, 1'b0);
    run_op(16'h3F81, 16'h3B80, 1'b0, 0, 1'b1);
    run_op(16'h7F80, 16'hFF80, 1'b0, 0, 1'b0);
    run_op(16'h7F7F, 16'h7F7F, 1'b0, 0, 1'b0);
    run_op(16'h8000, 16'h0000, 1'b1, 0, 1'b0);
    run_op(16'h7FC1, 16'h3F80, 1'b0, 0, 1'b0);
    run_op(16'h0001, 16'h8000, 1'b0, 0, 1'b0);
    run_op(16'h4049, 16'h3F80, 1'b0, 10, 1'b0);

    // Abort an operation while it sits in NORM.
    @(posedge clk); #2;
    a_i = 16'h3F80; b_i = 16'h3F80; sub_i = 1'b0; valid_i = 1'b1;
    @(posedge clk); #2 valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_i = 1'b1;
    #1;
    check("abort_valid",  {31'h0, valid_o}, 32'd0);
    check("abort_result", {16'h0, result_o}, 32'h0);
    check("abort_ready",  {31'h0, ready_o}, 32'd1);
    exp_q.delete();
    @(negedge clk) rst_i = 1'b0;
    repeat (6) @(negedge clk);
    run_op(16'h4000, 16'h4000, 1'b0, 0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      ra = 16'($urandom);
      if ($urandom_range(0, 7) == 0) ra[14:7] = ($urandom_range(0, 1) != 0) ? 8'd254 : 8'd1;
      k = int'($urandom_range(0, 9));
      if (k < 6) begin
        eb = int'(ra[14:7]) + int'($urandom_range(0, 24)) - 12;
        if (eb < 0)   eb = 0;
        if (eb > 255) eb = 255;
        rb = {1'($urandom), 8'(eb), 7'($urandom)};
      end else if (k == 6) begin
        rb = ra ^ 16'h8000;
      end else if (k == 7) begin
        case ($urandom_range(0, 4))
          0:       rb = 16'h7F80;
          1:       rb = 16'hFF80;
          2:       rb = 16'h7FC0;
          3:       rb = 16'h8000;
          default: rb = 16'h0000;
        endcase
      end else begin
        rb = 16'($urandom);
      end
      k = int'($urandom_range(0, 2));
      run_op(ra, rb, 1'($urandom), k, (k == 0) && ($urandom_range(0, 1) != 0));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bf16_add_seq.md
Name: bf16_add_seq

Overview:
- Multi-cycle bfloat16 adder/subtractor. Sits directly downstream of the integer-to-bf16 converter in the FPU and consumes its 16-bit bf16 results (sign[15], exp[14:7], man[6:0], bias 127).
- Valid/ready on both sides; one operation in flight at a time.
- Rounding is round-to-nearest-even; subnormals are flushed to zero.

Parameters:
- QNAN, 16'h7FC0, canonical quiet NaN driven on any NaN result.
- GUARD_W, 3, extra alignment bits below the LSB (guard, round, sticky); fixed at 3 for this release.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  operands valid.
- ready_o  out  1  high only in IDLE.
- a_i  in  16  bf16 operand A.
- b_i  in  16  bf16 operand B.
- sub_i  in  1  1 = compute A-B (flip B's sign at capture).
- valid_o  out  1  result valid.
- ready_i  in  1  consumer accepts the result.
- result_o  out  16  bf16 result.

Behaviour:
- Reset: state=IDLE; valid_o=0, result_o=16'h0000, ready_o=1. An asserted reset aborts any in-flight operation with no output.
- FSM: IDLE -> ALIGN -> ADD -> NORM -> DONE -> IDLE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, register a, b^{sub_i,15'b0}, then go to ALIGN.
- ALIGN:
  - Unpack; exp==0 means zero (mantissa forced 0).
  - Swap so |X|>=|Y|, comparing exponent then mantissa.
  - Significand = {1,man,3'b0} (11 bits).
  - Shift Y right by d=Ex-Ey. Shifted-out bits OR into the sticky bit.
  - If d>10, Y becomes sticky-only (1 if Y nonzero).
- Special-case detection happens in ALIGN and bypasses the arithmetic; the result is still delivered from DONE.
  - Any NaN, or inf + (-inf): result = QNAN.
  - Otherwise any inf: result = that inf.
  - Both zero: sign = sa&sb, so -0 + -0 = -0, else +0.
- ADD: 12-bit sum/difference of the aligned significands. Result sign = sign of X.
- NORM:
  - Carry out: shift right 1 (keep sticky), exp+1.
  - Otherwise: left-shift by leading-zero count, exp-lzc.
  - Zero difference: result +0.
  - Round to nearest even on G/R/S; a mantissa overflow after rounding increments exp.
  - Final exp >= 255: signed inf (exp 8'hFF, man 0).
  - Final exp <= 0: signed zero.
  - Use 10-bit signed exponent arithmetic internally.
- DONE:
  - valid_o=1; result_o stable.
  - When ready_i=1, go to IDLE and clear valid_o.
  - Otherwise hold indefinitely; the input is not accepted.
- Latency: valid_o rises exactly 4 cycles after the accepting edge. Throughput is at best 1 op per 5 cycles.
- ready_i high before DONE has no effect. valid_i outside IDLE is ignored (ready_o=0).

Optional Feature:
- Macro BF16_ADD_FLAGS_EN.
- Defined: adds output port flags_o[3:0] = {invalid, overflow, underflow, inexact}.
  - Flags are valid with valid_o and reset to 0.
  - invalid: NaN operand or inf-inf.
  - overflow: finite result rounded to inf.
  - underflow: nonzero result flushed to zero.
  - inexact: G|R|S nonzero, or overflow/underflow.
- Undefined: no flags_o port and no flag logic; all other behaviour is identical.

Decomposition:
- Package fpu_pkg:
  - bf16_t packed struct {sign, exp[7:0], man[6:0]}.
  - Constants BF16_BIAS=127, BF16_EXP_MAX=8'hFF, BF16_QNAN=16'h7FC0.
  - FSM enum add_state_e {IDLE, ALIGN, ADD, NORM, DONE}.
- Sub-module bf16_lzc: 12-bit leading-zero counter, combinational, 4-bit count output, used in NORM.

Test Plan:
- Sum with carry-out: a=3F80 (1.0), b=3F80, sub=0 -> result 4000 after 4 cycles; ready_o low for those cycles.
- Exact cancellation: a=3F80, b=3F80, sub=1 -> 0000.
- Tie rounds to even:
  - a=3F80, b=3B80 (2^-8) -> 3F80.
  - a=3F81, b=3B80 -> 3F82.
- Special cases:
  - a=7F80, b=FF80 -> 7FC0 (flags invalid with FLAGS_EN).
  - a=7F7F, b=7F7F -> 7F80 (overflow+inexact).
- Backpressure: hold ready_i=0 for 10 cycles in DONE -> result_o and valid_o stable, a new valid_i is not accepted; release -> IDLE next cycle.
- Reset: assert rst_i in NORM -> valid_o=0 and result_o=0000 immediately; the next operation 4000+4000 -> 4080.
